sm83_ctl_seq: RTL and testbench

Instruction sequencer for the SM83 core. It drives the strobes that fetch opcodes and operands from synchronous ROM through the PC register, and it steps the PC via the external incrementer. It loads the A register from the data bus. It sits between `mem`, `regfile_top` and `incrementer`, and only observes the shared address/data buses. It never drives either bus.

---
 rtl/sm83_ctl_pkg.sv | 34 +++
 rtl/ctl_decode.sv | 30 +++
 rtl/sm83_ctl_seq.sv | 108 ++++++++++
 tb/tb_sm83_ctl_seq.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm83_ctl_pkg.sv
// Shared types and constants for the SM83 instruction sequencer.
// Holds the FSM state enum, the decoded opcodes and the default bus widths.
`timescale 1ns/1ps
package sm83_ctl_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 16;

    localparam logic [7:0] OPC_NOP     = 8'h00;
    localparam logic [7:0] OPC_LD_A_D8 = 8'h3E;
    localparam logic [7:0] OPC_HALT    = 8'h76;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_F_ADDR = 3'd1,
        S_F_DATA = 3'd2,
        S_O_ADDR = 3'd3,
        S_O_DATA = 3'd4,
        S_HALT   = 3'd5
    } ctl_state_e;

    // One bit per strobe that the state decode can raise.
    typedef struct packed {
        logic pc_oe;
        logic pc_wr;
        logic pc_ld16;
        logic pc_inc_en;
        logic pc_inc_tap_en;
        logic a_wr;
        logic mem_cs;
        logic mem_oe;
    } ctl_out_t;

endpackage

// File: rtl/ctl_decode.sv
// Opcode to next-state map used while the opcode is on data_bus in F_DATA.
// Build option CTL_ILLEGAL_TRAP_EN: undecoded opcodes halt instead of acting as NOP.
`timescale 1ns/1ps
module ctl_decode
    import sm83_ctl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] i_opcode,
    output ctl_state_e        o_next
);

    always_comb begin
        // NOTE: every path assigns o_next (default first), so no latch is inferred.
        o_next = S_F_ADDR;
        case (i_opcode)
            DATA_W'(OPC_NOP):     o_next = S_F_ADDR;
            DATA_W'(OPC_LD_A_D8): o_next = S_O_ADDR;
            DATA_W'(OPC_HALT):    o_next = S_HALT;
            default: begin
`ifdef CTL_ILLEGAL_TRAP_EN
                o_next = S_HALT;
`else
                o_next = S_F_ADDR;
`endif
            end
        endcase
    end

endmodule

// File: rtl/sm83_ctl_seq.sv
// SM83 instruction sequencer: fetches opcodes/operands from synchronous ROM via the PC,
// steps the PC through the external incrementer and loads A. Option: CTL_ILLEGAL_TRAP_EN.
`timescale 1ns/1ps
module sm83_ctl_seq
    import sm83_ctl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [ADDR_W-1:0] addr_bus,
    inout  wire  [DATA_W-1:0] data_bus,
    output logic              pc_oe,
    output logic              pc_wr,
    output logic              pc_ldh,
    output logic              pc_ld16,
    output logic              pc_inc_en,
    output logic              pc_inc_tap_en,
    output logic              a_wr,
    output logic              a_oe,
    output logic              mem_cs,
    output logic              mem_oe
);

    ctl_state_e        r_state;
    ctl_state_e        w_next;
    ctl_state_e        w_dec_next;
    logic [DATA_W-1:0] r_ir;
    ctl_out_t          w_out;
    logic              w_unused;

    // The sequencer only observes the shared buses.
    assign addr_bus = 'z;
    assign data_bus = 'z;

    ctl_decode #(
        .DATA_W (DATA_W)
    ) u_decode (
        .i_opcode (data_bus),
        .o_next   (w_dec_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ir <= '0;
        end else if (r_state == S_F_DATA) begin
            r_ir <= data_bus;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST:    w_next = S_F_ADDR;
            S_F_ADDR: w_next = S_F_DATA;
            S_F_DATA: w_next = w_dec_next;
            S_O_ADDR: w_next = S_O_DATA;
            S_O_DATA: w_next = S_F_ADDR;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_RST;
        endcase
    end

    // Moore decode: the PC-step group accompanies every data phase.
    always_comb begin
        w_out = '0;
        case (r_state)
            S_F_ADDR, S_O_ADDR: begin
                w_out.pc_oe  = 1'b1;
                w_out.mem_cs = 1'b1;
            end
            S_F_DATA, S_O_DATA: begin
                w_out.mem_oe        = 1'b1;
                w_out.pc_inc_tap_en = 1'b1;
                w_out.pc_inc_en     = 1'b1;
                w_out.pc_wr         = 1'b1;
                w_out.pc_ld16       = 1'b1;
                w_out.a_wr          = (r_state == S_O_DATA);
            end
            default: w_out = '0;
        endcase
    end

    assign pc_oe         = w_out.pc_oe;
    assign pc_wr         = w_out.pc_wr;
    assign pc_ld16       = w_out.pc_ld16;
    assign pc_inc_en     = w_out.pc_inc_en;
    assign pc_inc_tap_en = w_out.pc_inc_tap_en;
    assign a_wr          = w_out.a_wr;
    assign mem_cs        = w_out.mem_cs;
    assign mem_oe        = w_out.mem_oe;
    assign pc_ldh        = 1'b0;
    assign a_oe          = 1'b0;

    // addr_bus is monitored only and IR has no consumer yet in this revision.
    assign w_unused = ^{addr_bus, r_ir};

endmodule

// File: tb/tb_sm83_ctl_seq.sv
// Self-checking bench for sm83_ctl_seq with a ROM/PC/A/incrementer environment model.
// Expected per-cycle strobes, PC, A and data_bus are queued per program and popped each cycle.
`timescale 1ns/1ps
module tb_sm83_ctl_seq;

    // Strobe vector: pc_oe pc_wr pc_ldh pc_ld16 pc_inc_en pc_inc_tap_en a_wr a_oe mem_cs mem_oe
    localparam logic [9:0] V_IDLE  = 10'b00_0000_0000;
    localparam logic [9:0] V_ADDR  = 10'b10_0000_0010;
    localparam logic [9:0] V_FDATA = 10'b01_0111_0001;
    localparam logic [9:0] V_ODATA = 10'b01_0111_1001;

    typedef struct packed {
        logic [9:0]  outs;
        logic [15:0] pc;
        logic [7:0]  a;
        logic        chk_d;
        logic [7:0]  d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic env_rst_n = 1'b0;
    always #5 clk = ~clk;

    wire [15:0] addr_bus;
    wire [7:0]  data_bus;
    logic pc_oe, pc_wr, pc_ldh, pc_ld16, pc_inc_en, pc_inc_tap_en;
    logic a_wr, a_oe, mem_cs, mem_oe;

    sm83_ctl_seq dut (
        .clk           (clk),
        .rst           (rst),
        .addr_bus      (addr_bus),
        .data_bus      (data_bus),
        .pc_oe         (pc_oe),
        .pc_wr         (pc_wr),
        .pc_ldh        (pc_ldh),
        .pc_ld16       (pc_ld16),
        .pc_inc_en     (pc_inc_en),
        .pc_inc_tap_en (pc_inc_tap_en),
        .a_wr          (a_wr),
        .a_oe          (a_oe),
        .mem_cs        (mem_cs),
        .mem_oe        (mem_oe)
    );

    wire [9:0] outs = {pc_oe, pc_wr, pc_ldh, pc_ld16, pc_inc_en, pc_inc_tap_en,
                       a_wr, a_oe, mem_cs, mem_oe};

    // Environment: ROM, PC register, incrementer and A register
    logic        rand_en = 1'b0;
    logic [15:0] rand_addr = 16'h0;
    logic [7:0]  rand_data = 8'h0;
    logic [15:0] env_pc;
    logic [7:0]  env_a;
    logic [15:0] rom_aq;
    logic [7:0]  rom [256];
    logic        addr_en, data_en;
    logic [15:0] addr_drv;
    logic [7:0]  data_drv;

    always_comb begin
        addr_en  = 1'b0;
        addr_drv = 16'h0;
        if (rand_en) begin
            addr_en  = 1'b1;
            addr_drv = rand_addr;
        end else if (pc_oe) begin
            addr_en  = 1'b1;
            addr_drv = env_pc;
        end else if (pc_inc_en && pc_inc_tap_en) begin
            addr_en  = 1'b1;
            addr_drv = env_pc + 16'd1;
        end
    end

    always_comb begin
        data_en  = rand_en | mem_oe;
        data_drv = rand_en ? rand_data : rom[rom_aq[7:0]];
    end

    assign addr_bus = addr_en ? addr_drv : 'z;
    assign data_bus = data_en ? data_drv : 'z;

    always @(posedge clk or negedge env_rst_n) begin
        if (!env_rst_n) begin
            env_pc <= 16'h0;
            env_a  <= 8'h0;
            rom_aq <= 16'h0;
        end else begin
            if (pc_wr && pc_ld16) env_pc <= addr_bus;
            if (a_wr)             env_a  <= data_bus;
            if (mem_cs)           rom_aq <= addr_bus;
        end
    end

    // Scoreboard
    exp_t  sb_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc   = 0;
    string tag   = "init";

    function automatic void push(input logic [9:0] o, input logic [15:0] p,
                                 input logic [7:0] a, input logic cd, input logic [7:0] d);
        exp_t e;
        e.outs = o; e.pc = p; e.a = a; e.chk_d = cd; e.d = d;
        sb_q.push_back(e);
    endfunction

    function automatic void exp_idle(input logic [15:0] p, input logic [7:0] a);
        push(V_IDLE, p, a, 1'b0, 8'h00);
    endfunction

    function automatic void exp_addr(input logic [15:0] p, input logic [7:0] a);
        push(V_ADDR, p, a, 1'b0, 8'h00);
    endfunction

    function automatic void exp_fetch(input logic [15:0] p, input logic [7:0] a, input logic [7:0] op);
        push(V_ADDR, p, a, 1'b0, 8'h00);
        push(V_FDATA, p, a, 1'b1, op);
    endfunction

    function automatic void exp_operand(input logic [15:0] p, input logic [7:0] a, input logic [7:0] d);
        push(V_ADDR, p, a, 1'b0, 8'h00);
        push(V_ODATA, p, a, 1'b1, d);
    endfunction

    task automatic check_cycle();
        exp_t e;
        e = sb_q.pop_front();
        cyc++;
        n_vec++;
        if (outs !== e.outs) begin
            n_err++;
            $display("FAIL %s cyc%0d strobes got %b want %b", tag, cyc, outs, e.outs);
        end
        n_vec++;
        if (env_pc !== e.pc) begin
            n_err++;
            $display("FAIL %s cyc%0d pc got %h want %h", tag, cyc, env_pc, e.pc);
        end
        n_vec++;
        if (env_a !== e.a) begin
            n_err++;
            $display("FAIL %s cyc%0d reg_a got %h want %h", tag, cyc, env_a, e.a);
        end
        if (e.chk_d) begin
            n_vec++;
            if (data_bus !== e.d) begin
                n_err++;
                $display("FAIL %s cyc%0d data_bus got %h want %h", tag, cyc, data_bus, e.d);
            end
        end
        if (e.outs[9]) begin
            n_vec++;
            if (addr_bus !== e.pc) begin
                n_err++;
                $display("FAIL %s cyc%0d addr_bus got %h want %h", tag, cyc, addr_bus, e.pc);
            end
        end
        n_vec++;
        if ((pc_oe & pc_inc_en) !== 1'b0 || (mem_oe & a_oe) !== 1'b0 || (pc_wr & ~pc_ld16) !== 1'b0) begin
            n_err++;
            $display("FAIL %s cyc%0d invariant got %b want no overlap", tag, cyc, outs);
        end
    endtask

    task automatic drain();
        while (sb_q.size() > 0) begin
            @(negedge clk);
            check_cycle();
        end
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    // Reset both DUT and environment; release just after an edge so the next sample sees RST.
    task automatic restart();
        rst       = 1'b0;
        env_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        env_rst_n = 1'b1;
        rst       = 1'b1;
        cyc       = 0;
    endtask

    task automatic test_reset();
        tag = "reset";
        #3 rst = 1'b0;
        rand_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rand_addr = 16'($urandom);
            rand_data = 8'($urandom);
            #1;
            n_vec++;
            if (outs !== V_IDLE) begin
                n_err++;
                $display("FAIL %s held%0d strobes got %b want %b", tag, i, outs, V_IDLE);
            end
        end
        rand_en = 1'b0;
        rom_clear();
        restart();
        exp_idle(16'h0, 8'h00);
        exp_fetch(16'h0, 8'h00, 8'h00);
        drain();
    endtask

    task automatic test_nop_stream();
        tag = "nop";
        rom_clear();
        restart();
        exp_idle(16'h0, 8'h00);
        exp_fetch(16'h0, 8'h00, 8'h00);
        exp_fetch(16'h1, 8'h00, 8'h00);
        exp_fetch(16'h2, 8'h00, 8'h00);
        exp_addr(16'h3, 8'h00);
        drain();
    endtask

    task automatic test_ld_a();
        tag = "ld_a";
        rom_clear();
        rom[0] = 8'h3E; rom[1] = 8'h5A; rom[2] = 8'h00;
        restart();
        exp_idle(16'h0, 8'h00);
        exp_fetch(16'h0, 8'h00, 8'h3E);
        exp_operand(16'h1, 8'h00, 8'h5A);
        exp_fetch(16'h2, 8'h5A, 8'h00);
        exp_addr(16'h3, 8'h5A);
        drain();
    endtask

    task automatic test_halt();
        tag = "halt";
        rom_clear();
        rom[0] = 8'h76;
        restart();
        exp_idle(16'h0, 8'h00);
        exp_fetch(16'h0, 8'h00, 8'h76);
        for (int i = 0; i < 22; i++) exp_idle(16'h1, 8'h00);
        drain();
    endtask

    task automatic test_illegal();
        tag = "illegal";
        rom_clear();
        rom[0] = 8'hD3; rom[1] = 8'h00;
        restart();
        exp_idle(16'h0, 8'h00);
        exp_fetch(16'h0, 8'h00, 8'hD3);
`ifdef CTL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 20; i++) exp_idle(16'h1, 8'h00);
`else
        exp_fetch(16'h1, 8'h00, 8'h00);
        exp_addr(16'h2, 8'h00);
`endif
        drain();
    endtask

    task automatic test_reset_abort();
        tag = "abort";
        rom_clear();
        rom[0] = 8'h3E; rom[1] = 8'h5A;
        restart();
        exp_idle(16'h0, 8'h00);
        exp_fetch(16'h0, 8'h00, 8'h3E);
        exp_addr(16'h1, 8'h00);
        drain();
        // Mid-cycle in O_ADDR: outputs must drop with no clock edge.
        #1 rst = 1'b0;
        #1;
        n_vec++;
        if (outs !== V_IDLE) begin
            n_err++;
            $display("FAIL %s async_drop strobes got %b want %b", tag, outs, V_IDLE);
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (env_a !== 8'h00 || outs !== V_IDLE) begin
            n_err++;
            $display("FAIL %s held reg_a got %h strobes %b want 00 and %b", tag, env_a, outs, V_IDLE);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        cyc = 0;
        exp_idle(16'h1, 8'h00);
        exp_addr(16'h1, 8'h00);
        drain();
    endtask

    task automatic test_back_to_back();
        tag = "b2b";
        rom_clear();
        rom[0] = 8'h3E; rom[1] = 8'h11; rom[2] = 8'h00;
        rom[3] = 8'h3E; rom[4] = 8'h22; rom[5] = 8'h76;
        restart();
        exp_idle(16'h0, 8'h00);
        exp_fetch(16'h0, 8'h00, 8'h3E);
        exp_operand(16'h1, 8'h00, 8'h11);
        exp_fetch(16'h2, 8'h11, 8'h00);
        exp_fetch(16'h3, 8'h11, 8'h3E);
        exp_operand(16'h4, 8'h11, 8'h22);
        exp_fetch(16'h5, 8'h22, 8'h76);
        for (int i = 0; i < 3; i++) exp_idle(16'h6, 8'h22);
        drain();
    endtask

    initial begin
        rom_clear();
        test_reset();
        test_nop_stream();
        test_ld_a();
        test_halt();
        test_illegal();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
